// File: rtl/ram_pkg.sv
// Shared sizing and FSM encoding for the RAM-backed FIFO controller.
package ram_pkg;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sync_ram_fifo_ctrl_if.sv
// Bundle of FIFO handshake, RAM-side and status signals for sync_ram_fifo_ctrl.
interface sync_ram_fifo_ctrl_if #(
  parameter int DW = ram_pkg::DW,
  parameter int AW = ram_pkg::AW
);

  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_req;
  logic          rd_ack;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic [AW:0]   count;
  logic          full;
  logic          empty;

  // Master is the surrounding system: producer, consumer and the RAM itself.
  modport master (
    output wr_valid, wr_data, rd_req, ram_dout,
    input  wr_ready, rd_ack, rd_valid, rd_data, ram_we, ram_addr, ram_din,
           count, full, empty
  );

  modport slave (
    input  wr_valid, wr_data, rd_req, ram_dout,
    output wr_ready, rd_ack, rd_valid, rd_data, ram_we, ram_addr, ram_din,
           count, full, empty
  );

endinterface

// File: rtl/sync_ram_fifo_ctrl.sv
// FIFO controller over an external single-port synchronous RAM: clears the RAM
// after reset, then serves one access per cycle with reads taking priority.
module sync_ram_fifo_ctrl #(
  parameter int DW = ram_pkg::DW,
  parameter int AW = ram_pkg::AW
) (
  input logic                 clk,
  input logic                 rst,
  sync_ram_fifo_ctrl_if.slave bus
);
  import ram_pkg::*;

  state_t        state;
  logic [AW-1:0] init_cnt;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          rd_valid_q;

  logic          run;
  logic          empty;
  logic          full;
  logic          rd_grant;
  logic          wr_ok;
  logic          wr_accept;
  logic          ram_we_c;
  logic [AW-1:0] ram_addr_c;
  logic [DW-1:0] ram_din_c;

  // Only occupancy 2**AW sets the top bit, so it alone signals full.
  assign run       = (state == RUN);
  assign empty     = (count == '0);
  assign full      = count[AW];
  assign rd_grant  = run && bus.rd_req && !empty;
  assign wr_ok     = run && !full && !(bus.rd_req && !empty);
  assign wr_accept = wr_ok && bus.wr_valid;

  always_comb begin
    ram_we_c   = 1'b0;
    ram_addr_c = rd_ptr;
    ram_din_c  = '0;
    if (!run) begin
      ram_we_c   = 1'b1;
      ram_addr_c = init_cnt;
    end else if (!rd_grant && wr_accept) begin
      ram_we_c   = 1'b1;
      ram_addr_c = wr_ptr;
      ram_din_c  = bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      init_cnt   <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      rd_valid_q <= 1'b0;
    end else if (!run) begin
      rd_valid_q <= 1'b0;
      init_cnt   <= init_cnt + 1'b1;
      if (init_cnt == '1) begin
        state <= RUN;
      end
    end else begin
      rd_valid_q <= rd_grant;
      if (rd_grant) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 1'b1;
      end else if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end
    end
  end

  assign bus.wr_ready = wr_ok;
  assign bus.rd_ack   = rd_grant;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = bus.ram_dout;
  assign bus.ram_we   = ram_we_c;
  assign bus.ram_addr = ram_addr_c;
  assign bus.ram_din  = ram_din_c;
  assign bus.count    = count;
  assign bus.full     = full;
  assign bus.empty    = empty;

endmodule

// File: tb/tb_sync_ram_fifo_ctrl.sv
// Bench for sync_ram_fifo_ctrl: queue-based reference model checked every cycle
// plus directed scenarios with literal expectations.
module tb_sync_ram_fifo_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  sync_ram_fifo_ctrl_if #(.DW(8), .AW(3)) bus ();

  sync_ram_fifo_ctrl #(.DW(8), .AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM: read data only refreshes on non-write cycles.
  logic [7:0] mem [8];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    else            bus.ram_dout <= mem[bus.ram_addr];
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy as a queue, INIT as a countdown, addresses as
  // running totals of accepted operations modulo the depth.
  logic [7:0] q [$];
  bit         known;
  int         init_left;
  int         rd_total;
  int         wr_total;
  bit         pend_v;
  logic [7:0] pend_d;

  always @(negedge clk) begin : model_chk
    int sz;
    bit run, rd_g, wr_rdy, wr_g;
    if (known) begin
      sz     = q.size();
      run    = (init_left == 0);
      rd_g   = run && bus.rd_req && (sz > 0);
      wr_rdy = run && (sz < 8) && !(bus.rd_req && (sz > 0));
      wr_g   = wr_rdy && bus.wr_valid;
      check_output("m_rd_ack",   32'(bus.rd_ack),   32'(rd_g));
      check_output("m_wr_ready", 32'(bus.wr_ready), 32'(wr_rdy));
      check_output("m_count",    32'(bus.count),    32'(sz));
      check_output("m_full",     32'(bus.full),     32'(sz == 8));
      check_output("m_empty",    32'(bus.empty),    32'(sz == 0));
      check_output("m_rd_valid", 32'(bus.rd_valid), 32'(pend_v));
      if (pend_v) check_output("m_rd_data", 32'(bus.rd_data), 32'(pend_d));
      if (!run) begin
        check_output("m_init_we",   32'(bus.ram_we),   32'd1);
        check_output("m_init_addr", 32'(bus.ram_addr), 32'(8 - init_left));
        check_output("m_init_din",  32'(bus.ram_din),  32'd0);
      end else if (rd_g) begin
        check_output("m_rd_we",   32'(bus.ram_we),   32'd0);
        check_output("m_rd_addr", 32'(bus.ram_addr), 32'(rd_total % 8));
      end else if (wr_g) begin
        check_output("m_wr_we",   32'(bus.ram_we),   32'd1);
        check_output("m_wr_addr", 32'(bus.ram_addr), 32'(wr_total % 8));
        check_output("m_wr_din",  32'(bus.ram_din),  32'(bus.wr_data));
      end else begin
        check_output("m_idle_we",   32'(bus.ram_we),   32'd0);
        check_output("m_idle_addr", 32'(bus.ram_addr), 32'(rd_total % 8));
      end
    end
    if (rst) begin
      known     = 1'b1;
      init_left = 8;
      q.delete();
      rd_total  = 0;
      wr_total  = 0;
      pend_v    = 1'b0;
    end else if (known) begin
      pend_v = 1'b0;
      if (init_left > 0) begin
        init_left--;
      end else if (bus.rd_req && q.size() > 0) begin
        pend_v = 1'b1;
        pend_d = q.pop_front();
        rd_total++;
      end else if (bus.wr_valid && q.size() < 8) begin
        q.push_back(bus.wr_data);
        wr_total++;
      end
    end
  end

  // One cycle of stimulus; returns at the following negedge for sampling.
  task automatic apply_stimulus(input logic wv, input logic [7:0] wd, input logic rq);
    @(posedge clk);
    #1;
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_req   = rq;
    @(negedge clk);
  endtask

  logic [7:0] vals [3];

  initial begin
    checks       = 0;
    failures     = 0;
    known        = 1'b0;
    rst          = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    bus.rd_req   = 1'b0;
    vals[0] = 8'h11;
    vals[1] = 8'h22;
    vals[2] = 8'h33;

    // Reset then the eight-cycle RAM clear.
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_output("lit_init_we",    32'(bus.ram_we),   32'd1);
      check_output("lit_init_addr",  32'(bus.ram_addr), 32'(i));
      check_output("lit_init_din",   32'(bus.ram_din),  32'd0);
      check_output("lit_init_wrrdy", 32'(bus.wr_ready), 32'd0);
      check_output("lit_init_empty", 32'(bus.empty),    32'd1);
    end
    apply_stimulus(1'b0, 8'h00, 1'b0);
    check_output("lit_run_wrrdy", 32'(bus.wr_ready), 32'd1);
    check_output("lit_run_empty", 32'(bus.empty),    32'd1);

    // Three writes then three reads.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, vals[i], 1'b0);
      check_output("lit_w3_wrrdy", 32'(bus.wr_ready), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 8'h00, 1'b1);
      check_output("lit_r3_ack",   32'(bus.rd_ack), 32'd1);
      check_output("lit_r3_count", 32'(bus.count),  32'(3 - i));
      if (i > 0) check_output("lit_r3_data", 32'(bus.rd_data), 32'(vals[i-1]));
    end
    apply_stimulus(1'b0, 8'h00, 1'b0);
    check_output("lit_r3_valid", 32'(bus.rd_valid), 32'd1);
    check_output("lit_r3_last",  32'(bus.rd_data),  32'h33);
    check_output("lit_r3_zero",  32'(bus.count),    32'd0);

    // Fill to full, offer a ninth word, then drain.
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 8'(8'h80 + i), 1'b0);
    apply_stimulus(1'b1, 8'h99, 1'b0);
    check_output("lit_full",       32'(bus.full),     32'd1);
    check_output("lit_full_count", 32'(bus.count),    32'd8);
    check_output("lit_full_wrrdy", 32'(bus.wr_ready), 32'd0);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b0, 8'h00, 1'b1);
      if (i == 0) check_output("lit_ninth_ignored", 32'(bus.count), 32'd8);
      if (i > 0)  check_output("lit_drain_data", 32'(bus.rd_data), 32'(8'h80 + i - 1));
    end
    apply_stimulus(1'b0, 8'h00, 1'b0);
    check_output("lit_drain_last",  32'(bus.rd_data), 32'h87);
    check_output("lit_drain_empty", 32'(bus.empty),   32'd1);

    // Simultaneous write and read with two entries: read wins.
    apply_stimulus(1'b1, 8'h41, 1'b0);
    apply_stimulus(1'b1, 8'h42, 1'b0);
    apply_stimulus(1'b1, 8'h43, 1'b1);
    check_output("lit_both_ack",   32'(bus.rd_ack),   32'd1);
    check_output("lit_both_wrrdy", 32'(bus.wr_ready), 32'd0);
    apply_stimulus(1'b0, 8'h00, 1'b0);
    check_output("lit_both_count", 32'(bus.count),   32'd1);
    check_output("lit_both_data",  32'(bus.rd_data), 32'h41);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b0);
    check_output("lit_both_data2", 32'(bus.rd_data), 32'h42);

    // Alternating write/read pairs wrap both pointers.
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(1'b1, 8'(8'hA0 + i), 1'b0);
      if (i > 0) check_output("lit_wrap_data", 32'(bus.rd_data), 32'(8'hA0 + i - 1));
      apply_stimulus(1'b0, 8'h00, 1'b1);
    end
    apply_stimulus(1'b0, 8'h00, 1'b0);
    check_output("lit_wrap_last",  32'(bus.rd_data), 32'hAB);
    check_output("lit_wrap_count", 32'(bus.count),   32'd0);

    // Reset with five entries held: contents must be discarded.
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 8'(8'hC0 + i), 1'b0);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.wr_valid = 1'b0;
    @(negedge clk);
    check_output("lit_prerst_count", 32'(bus.count), 32'd5);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    bus.rd_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_output("lit_reinit_addr",  32'(bus.ram_addr), 32'(i));
      check_output("lit_reinit_ack",   32'(bus.rd_ack),   32'd0);
      check_output("lit_reinit_count", 32'(bus.count),    32'd0);
      check_output("lit_reinit_valid", 32'(bus.rd_valid), 32'd0);
    end
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check_output("lit_stale_ack", 32'(bus.rd_ack), 32'd0);
    apply_stimulus(1'b0, 8'h00, 1'b0);
    check_output("lit_stale_valid", 32'(bus.rd_valid), 32'd0);
    apply_stimulus(1'b1, 8'hD5, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b0);
    check_output("lit_fresh_data", 32'(bus.rd_data), 32'hD5);

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_ram_fifo_ctrl.md
SYNC_RAM_FIFO_CTRL -- requirements
Module: sync_ram_fifo_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, data width in bits.
REQ-002 SHALL have parameter AW, default 3, RAM address width; depth = 2**AW = 8.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port wr_valid  input  1  producer offers wr_data this cycle.
REQ-006 SHALL have port wr_data  input  DW  data to enqueue.
REQ-007 SHALL have port wr_ready  output  1  write accepted this cycle when wr_valid&&wr_ready.
REQ-008 SHALL have port rd_req  input  1  consumer requests one word.
REQ-009 SHALL have port rd_ack  output  1  read granted this cycle when rd_req&&rd_ack.
REQ-010 SHALL have port rd_valid  output  1  rd_data holds the granted word, one cycle after grant.
REQ-011 SHALL have port rd_data  output  DW  dequeued data, meaningful only when rd_valid=1.
REQ-012 SHALL have port ram_we  output  1  write enable to downstream single-port sync RAM.
REQ-013 SHALL have port ram_addr  output  AW  RAM address.
REQ-014 SHALL have port ram_din  output  DW  RAM write data.
REQ-015 SHALL have port ram_dout  input  DW  RAM registered read data (updates only on cycles with ram_we=0).
REQ-016 SHALL have ports count (AW+1 bits), full, empty  outputs  occupancy 0..8, count==8, count==0.

Function
REQ-017 SHALL implement a 2-state FSM: INIT (clear RAM) and RUN (FIFO operation).
REQ-018 SHALL, in INIT, drive ram_we=1, ram_din=0, ram_addr=init_cnt, incrementing init_cnt each cycle from 0 to 7.
REQ-019 SHALL move INIT->RUN on the cycle after writing address 7 (INIT lasts exactly 8 cycles after rst deasserts).
REQ-020 SHALL hold wr_ready=0 and rd_ack=0 throughout INIT.
REQ-021 SHALL perform at most one RAM access per cycle (single-port target).
REQ-022 SHALL, in RUN, assert rd_ack = rd_req && !empty (reads have priority).
REQ-023 SHALL, in RUN, assert wr_ready = !full && !(rd_req && !empty).
REQ-024 SHALL, on a granted read, drive ram_we=0, ram_addr=rd_ptr; rd_ptr+1 and count-1 at posedge.
REQ-025 SHALL, on an accepted write, drive ram_we=1, ram_addr=wr_ptr, ram_din=wr_data; wr_ptr+1 and count+1 at posedge.
REQ-026 SHALL, when neither occurs, drive ram_we=0, ram_addr=rd_ptr (idle read, no state change, rd_valid stays 0).
REQ-027 SHALL register rd_valid=1 the cycle after a grant; rd_data = ram_dout combinationally (read latency 1 cycle).
REQ-028 SHALL wrap rd_ptr and wr_ptr modulo 8 (7->0) without affecting count.
REQ-029 SHALL ignore wr_valid when full and rd_req when empty (no pointer/count change, no error flag).
REQ-030 SHALL drive ram_we/ram_addr/ram_din combinationally from FSM state, pointers and current requests.

Reset
REQ-031 SHALL, while rst=1 at posedge, set state=INIT, init_cnt=0, rd_ptr=0, wr_ptr=0, count=0, rd_valid=0.
REQ-032 SHALL, during and after reset until RUN, present full=0, empty=1, wr_ready=0, rd_ack=0.
REQ-033 SHALL, on rst mid-INIT or mid-RUN, discard all contents and restart the full 8-cycle clear.

Structure
REQ-034 SHALL place DW, AW, DEPTH and the FSM state encoding (INIT=1'b0, RUN=1'b1) in a shared package ram_pkg.
REQ-035 SHALL be a single flat module; the RAM is instantiated alongside it in the parent, not inside.

Verification
REQ-036 SHALL check: rst 1 cycle then release -> ram_we=1, addresses 0..7 with din 0 over 8 cycles, then wr_ready=1, empty=1.
REQ-037 SHALL check: write 0x11,0x22,0x33 then 3 reads -> rd_valid one cycle after each rd_ack, data 0x11,0x22,0x33, count 3->0.
REQ-038 SHALL check: 8 writes 0x80..0x87 -> full=1, count=8, wr_ready=0; 9th write ignored; 8 reads return 0x80..0x87.
REQ-039 SHALL check: count=2, simultaneous wr_valid and rd_req -> rd_ack=1, wr_ready=0, count=1 next cycle.
REQ-040 SHALL check: 12 alternating write/read pairs -> pointers wrap 7->0, all data returned in order, count ends 0.
REQ-041 SHALL check: rst asserted with count=5 -> next cycles re-run 8-cycle INIT, count=0, rd_valid=0, stale data never returned.
